// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-memory read bus between fetch stage and memory
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: one outstanding read, single-entry buffer, IF/ID register
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [5:0]  stall,
  input  logic        flush,
  if_fetch_if.master  mem,
  output logic        stallreq_if,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, REQ, READY} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] inst_buf;
  logic        drop_q;
  logic        req_q;

  // PC freezing (stall[0]) and later-stage stall bits belong to other blocks.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      inst_buf    <= '0;
      drop_q      <= 1'b0;
      req_q       <= 1'b0;
      stallreq_if <= 1'b1;
      id_pc       <= '0;
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
    end else begin
      // IF/ID register: flush beats stall, stall holds, otherwise buffer or bubble.
      if (flush || (!stall[1] && state != READY)) begin
        id_pc    <= '0;
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end else if (!stall[1]) begin
        id_pc    <= addr_q;
        id_inst  <= inst_buf;
        id_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (!flush) begin
            addr_q <= pc;
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            req_q <= 1'b0;
            if (drop_q || flush) begin
              drop_q <= 1'b0;
              state  <= ISSUE;
            end else begin
              inst_buf    <= mem.mem_rdata;
              stallreq_if <= 1'b0;
              state       <= READY;
            end
          end else if (flush) begin
            // The access cannot be cancelled; remember to throw its data away.
            drop_q <= 1'b1;
          end
        end
        READY: begin
          if (flush || !stall[1]) begin
            stallreq_if <= 1'b1;
            state       <= ISSUE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch against a fetch-lifecycle model
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  if_fetch_if mem_bus();

  if_fetch #(.NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .stall       (stall),
    .flush       (flush),
    .mem         (mem_bus),
    .stallreq_if (stallreq_if),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Lifecycle of one fetch: waiting to issue -> outstanding -> buffered -> handed to decode.
  bit          boot, want_issue, outstanding, drop, buffered;
  logic [31:0] req_addr, buf_addr, buf_data;
  bit          exp_valid;
  logic [31:0] exp_pc, exp_inst;
  int          lat;
  int          max_lat, stall_pct, flush_pct;

  task automatic model_reset();
    boot = 1; want_issue = 0; outstanding = 0; drop = 0; buffered = 0;
    req_addr = '0; buf_addr = '0; buf_data = '0;
    exp_valid = 0; exp_pc = '0; exp_inst = NOP; lat = 0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mem_bus.mem_ack = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check_eq("rst_stallreq", 32'(stallreq_if), 32'd1);
    check_eq("rst_id_pc", id_pc, 32'd0);
    check_eq("rst_id_inst", id_inst, NOP);
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    bit f, s, a;
    f = ($urandom_range(0, 99) < flush_pct);
    stall = 6'($urandom);
    stall[1] = ($urandom_range(0, 99) < stall_pct);
    s = stall[1];
    pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
    a = 0;
    if (outstanding) begin
      if (lat == 0) a = 1;
      else lat--;
    end else if (boot || (want_issue && $urandom_range(0, 3) == 0)) begin
      a = 1;  // stray ack that must be ignored
    end
    mem_bus.mem_ack   = a;
    mem_bus.mem_rdata = (a && outstanding) ? mem_word(req_addr) : $urandom;
    flush = f;

    // Decode-side view for the coming edge.
    if (f) begin
      exp_valid = 0; exp_pc = '0; exp_inst = NOP;
    end else if (!s) begin
      if (buffered) begin
        exp_valid = 1; exp_pc = buf_addr; exp_inst = buf_data;
      end else begin
        exp_valid = 0; exp_pc = '0; exp_inst = NOP;
      end
    end

    // Fetch-side lifecycle for the coming edge.
    if (boot) begin
      boot = 0; want_issue = 1;
    end else if (want_issue) begin
      if (!f) begin
        want_issue = 0; outstanding = 1; req_addr = pc;
        lat = $urandom_range(0, max_lat);
      end
    end else if (outstanding) begin
      if (a) begin
        outstanding = 0;
        if (drop || f) begin
          drop = 0; want_issue = 1;
        end else begin
          buffered = 1; buf_addr = req_addr; buf_data = mem_word(req_addr);
        end
      end else if (f) begin
        drop = 1;
      end
    end else if (buffered) begin
      if (f || !s) begin
        buffered = 0; want_issue = 1;
      end
    end

    @(negedge clk);
    check_eq("stallreq_if", 32'(stallreq_if), 32'(!buffered));
    check_eq("mem_req", 32'(mem_bus.mem_req), 32'(outstanding));
    check_eq("mem_addr", mem_bus.mem_addr, req_addr);
    check_eq("id_valid", 32'(id_valid), 32'(exp_valid));
    check_eq("id_pc", id_pc, exp_pc);
    check_eq("id_inst", id_inst, exp_inst);
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    max_lat = 0; stall_pct = 0; flush_pct = 0;
    @(negedge clk);
    do_reset();

    // Zero-wait memory, no stalls or flushes: one instruction every 3 cycles.
    repeat (30) step();

    max_lat = 3; stall_pct = 30; flush_pct = 10;
    repeat (400) step();

    // Reset landing in the middle of an outstanding access.
    for (int k = 0; k < 6; k++) begin
      for (int n = 0; n < 200 && !outstanding; n++) step();
      do_reset();
      repeat (150) step();
    end

    max_lat = 1; stall_pct = 60; flush_pct = 25;
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
